// File: rtl/proc_pkg.sv
// Shared pipeline definitions: default widths, the zero register index and
// the multdiv scoreboard state encoding.
package proc_pkg;

  localparam int DW_DEF   = 32;
  localparam int RW_DEF   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/bypass_hist_buf.sv
// Shift buffer of recent W-stage register writes with three parallel
// lookup ports (operand A, operand B, store data); entry 0 is youngest.
module bypass_hist_buf #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int HIST = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [RW-1:0] push_reg_i,
  input  logic [DW-1:0] push_data_i,
  input  logic [RW-1:0] a_reg_i,
  output logic          a_hit_o,
  output logic [DW-1:0] a_data_o,
  input  logic [RW-1:0] b_reg_i,
  output logic          b_hit_o,
  output logic [DW-1:0] b_data_o,
  input  logic [RW-1:0] s_reg_i,
  output logic          s_hit_o,
  output logic [DW-1:0] s_data_o
);

  logic [HIST-1:0] vld_q;
  logic [RW-1:0]   reg_q [HIST];
  logic [DW-1:0]   dat_q [HIST];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else if (push_i) begin
      vld_q[0] <= 1'b1;
      for (int i = 1; i < HIST; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload needs no reset: it is only ever read qualified by vld_q.
  always_ff @(posedge clock) begin
    if (push_i) begin
      reg_q[0] <= push_reg_i;
      dat_q[0] <= push_data_i;
      for (int i = 1; i < HIST; i++) begin
        reg_q[i] <= reg_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching entry overrides.
  function automatic logic [DW:0] lookup(input logic [RW-1:0] r);
    logic [DW:0] res;
    res = '0;
    for (int i = HIST - 1; i >= 0; i--) begin
      if (vld_q[i] && reg_q[i] == r) res = {1'b1, dat_q[i]};
    end
    return res;
  endfunction

  always_comb begin
    {a_hit_o, a_data_o} = lookup(a_reg_i);
    {b_hit_o, b_data_o} = lookup(b_reg_i);
    {s_hit_o, s_data_o} = lookup(s_reg_i);
  end

endmodule

// File: rtl/bypass_stall_unit.sv
// Operand forwarding, load-use / multdiv hazard stall and multdiv scoreboard
// for the 5-stage pipeline; all forwarding paths are purely combinational.
module bypass_stall_unit
  import proc_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int RW     = RW_DEF,
  parameter int HIST   = 2,
  parameter int MD_TMO = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          x_a_use,
  input  logic [RW-1:0] x_a_reg,
  input  logic [DW-1:0] x_a_rf,
  input  logic          x_b_use,
  input  logic [RW-1:0] x_b_reg,
  input  logic [DW-1:0] x_b_rf,
  input  logic          x_is_md,
  input  logic          m_wr_en,
  input  logic [RW-1:0] m_wr_reg,
  input  logic [DW-1:0] m_wr_data,
  input  logic          m_is_load,
  input  logic [RW-1:0] m_st_reg,
  input  logic [DW-1:0] m_st_in,
  input  logic          w_wr_en,
  input  logic [RW-1:0] w_wr_reg,
  input  logic [DW-1:0] w_wr_data,
  input  logic          md_start,
  input  logic [RW-1:0] md_dst,
  input  logic          md_done,
  input  logic [DW-1:0] md_result,
  output logic [DW-1:0] x_a_out,
  output logic [DW-1:0] x_b_out,
  output logic [DW-1:0] m_st_out,
  output logic          stall,
  output logic          md_busy,
  output logic          md_timeout
);

  localparam int            CW    = $clog2(MD_TMO + 1);
  localparam logic [CW-1:0] TMO_C = CW'(MD_TMO);
  localparam logic [RW-1:0] R0    = RW'(REG_ZERO);

  md_state_e     state_q, state_d;
  logic [RW-1:0] md_dst_q, md_dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic          ha_hit, hb_hit, hs_hit;
  logic [DW-1:0] ha_dat, hb_dat, hs_dat;

  bypass_hist_buf #(.DW(DW), .RW(RW), .HIST(HIST)) u_hist (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_i     (w_wr_en && w_wr_reg != R0),
    .push_reg_i (w_wr_reg),
    .push_data_i(w_wr_data),
    .a_reg_i    (x_a_reg),
    .a_hit_o    (ha_hit),
    .a_data_o   (ha_dat),
    .b_reg_i    (x_b_reg),
    .b_hit_o    (hb_hit),
    .b_data_o   (hb_dat),
    .s_reg_i    (m_st_reg),
    .s_hit_o    (hs_hit),
    .s_data_o   (hs_dat)
  );

  assign md_busy    = (state_q == MD_BUSY);
  assign md_timeout = tmo_q;

  function automatic logic [DW-1:0] fwd_sel(input logic en, input logic [RW-1:0] r,
                                            input logic [DW-1:0] rf, input logic hhit,
                                            input logic [DW-1:0] hdat);
    logic [DW-1:0] v;
    v = rf;
    if (en && r != R0) begin
      if (md_done && md_busy && r == md_dst_q)         v = md_result;
      else if (m_wr_en && !m_is_load && r == m_wr_reg) v = m_wr_data;
      else if (w_wr_en && r == w_wr_reg)               v = w_wr_data;
      else if (hhit)                                   v = hdat;
    end
    return v;
  endfunction

  logic a_lu, b_lu, a_md, b_md, load_use, md_hazard;

  always_comb begin
    x_a_out = fwd_sel(x_a_use, x_a_reg, x_a_rf, ha_hit, ha_dat);
    x_b_out = fwd_sel(x_b_use, x_b_reg, x_b_rf, hb_hit, hb_dat);
    // Store data is read in M, so only W and older writes can be newer.
    m_st_out = m_st_in;
    if (m_st_reg != R0) begin
      if (w_wr_en && m_st_reg == w_wr_reg) m_st_out = w_wr_data;
      else if (hs_hit)                     m_st_out = hs_dat;
    end
    a_lu      = x_a_use && x_a_reg != R0 && x_a_reg == m_wr_reg;
    b_lu      = x_b_use && x_b_reg != R0 && x_b_reg == m_wr_reg;
    a_md      = x_a_use && x_a_reg != R0 && x_a_reg == md_dst_q;
    b_md      = x_b_use && x_b_reg != R0 && x_b_reg == md_dst_q;
    load_use  = m_is_load && m_wr_en && (a_lu || b_lu);
    md_hazard = md_busy && (((a_md || b_md) && !md_done) || x_is_md);
    stall     = reset_n && (load_use || md_hazard);
  end

  always_comb begin
    state_d  = state_q;
    md_dst_d = md_dst_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start && md_dst != R0) begin
          state_d  = MD_BUSY;
          md_dst_d = md_dst;
          cnt_d    = '0;
        end
      end
      MD_BUSY: begin
        if (cnt_q != TMO_C) cnt_d = cnt_q + 1'b1;
        if (md_start && md_dst != R0) md_dst_d = md_dst;
        else if (md_done)             state_d  = MD_IDLE;
        if (cnt_d == TMO_C) tmo_d = 1'b1;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MD_IDLE;
      md_dst_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_dst_q <= md_dst_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_bypass_stall_unit.sv
// Directed bench for bypass_stall_unit: expectations are queued as each step is
// driven and popped in order against the sampled DUT outputs.
module tb_bypass_stall_unit;

  logic        clock, reset_n;
  logic        x_a_use, x_b_use, x_is_md, m_wr_en, m_is_load, w_wr_en, md_start, md_done;
  logic [4:0]  x_a_reg, x_b_reg, m_wr_reg, m_st_reg, w_wr_reg, md_dst;
  logic [31:0] x_a_rf, x_b_rf, m_wr_data, m_st_in, w_wr_data, md_result;
  logic [31:0] x_a_out, x_b_out, m_st_out;
  logic        stall, md_busy, md_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  bypass_stall_unit dut (
    .clock(clock), .reset_n(reset_n),
    .x_a_use(x_a_use), .x_a_reg(x_a_reg), .x_a_rf(x_a_rf),
    .x_b_use(x_b_use), .x_b_reg(x_b_reg), .x_b_rf(x_b_rf),
    .x_is_md(x_is_md),
    .m_wr_en(m_wr_en), .m_wr_reg(m_wr_reg), .m_wr_data(m_wr_data),
    .m_is_load(m_is_load), .m_st_reg(m_st_reg), .m_st_in(m_st_in),
    .w_wr_en(w_wr_en), .w_wr_reg(w_wr_reg), .w_wr_data(w_wr_data),
    .md_start(md_start), .md_dst(md_dst), .md_done(md_done), .md_result(md_result),
    .x_a_out(x_a_out), .x_b_out(x_b_out), .m_st_out(m_st_out),
    .stall(stall), .md_busy(md_busy), .md_timeout(md_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_in();
    x_a_use = 0; x_a_reg = 0; x_a_rf = 0;
    x_b_use = 0; x_b_reg = 0; x_b_rf = 0;
    x_is_md = 0;
    m_wr_en = 0; m_wr_reg = 0; m_wr_data = 0; m_is_load = 0;
    m_st_reg = 0; m_st_in = 0;
    w_wr_en = 0; w_wr_reg = 0; w_wr_data = 0;
    md_start = 0; md_dst = 0; md_done = 0; md_result = 0;
  endtask

  task automatic push_exp(input string t, input logic [31:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    idle_in();
  endtask

  initial begin
    idle_in();
    reset_n = 1'b0;
    x_is_md = 1'b1;
    #1;
    push_exp("rst_busy", 0); push_exp("rst_tmo", 0); push_exp("rst_stall", 0);
    chk(32'(md_busy)); chk(32'(md_timeout)); chk(32'(stall));
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // M-stage forwarding; unused operand passes regfile through.
    step();
    m_wr_en = 1; m_wr_reg = 3; m_wr_data = 5;
    x_a_use = 1; x_a_reg = 3; x_a_rf = 0;
    x_b_use = 0; x_b_reg = 3; x_b_rf = 32'h77;
    #1;
    push_exp("m_fwd_a", 5); push_exp("b_unused", 32'h77); push_exp("m_fwd_stall", 0);
    chk(x_a_out); chk(x_b_out); chk(32'(stall));

    // W write of r4, then history read next cycle.
    step();
    w_wr_en = 1; w_wr_reg = 4; w_wr_data = 9;
    x_b_use = 1; x_b_reg = 4; x_b_rf = 0;
    #1;
    push_exp("w_fwd_b", 9); chk(x_b_out);

    step();
    x_b_use = 1; x_b_reg = 4; x_b_rf = 0;
    x_a_use = 1; x_a_reg = 5; x_a_rf = 32'h21;
    m_st_reg = 4; m_st_in = 32'h55;
    #1;
    push_exp("hist_b", 9); push_exp("hist_miss_a", 32'h21); push_exp("hist_st", 9);
    chk(x_b_out); chk(x_a_out); chk(m_st_out);

    step();
    w_wr_en = 1; w_wr_reg = 4; w_wr_data = 32'h11;
    x_b_use = 1; x_b_reg = 4; x_b_rf = 0;
    m_st_reg = 4; m_st_in = 32'h55;
    #1;
    push_exp("w_over_hist", 32'h11); push_exp("st_w_fwd", 32'h11);
    chk(x_b_out); chk(m_st_out);

    step();
    x_b_use = 1; x_b_reg = 4; x_b_rf = 0;
    #1;
    push_exp("hist_youngest", 32'h11); chk(x_b_out);

    step();
    m_wr_en = 1; m_wr_reg = 4; m_wr_data = 32'hAA;
    w_wr_en = 1; w_wr_reg = 4; w_wr_data = 32'hBB;
    x_b_use = 1; x_b_reg = 4; x_b_rf = 0;
    #1;
    push_exp("m_over_w", 32'hAA); chk(x_b_out);

    // Load-use stall, then the load's data arrives from W.
    step();
    m_wr_en = 1; m_is_load = 1; m_wr_reg = 7; m_wr_data = 32'hDEAD;
    x_a_use = 1; x_a_reg = 7; x_a_rf = 0;
    #1;
    push_exp("lu_stall", 1); push_exp("lu_no_mfwd", 0);
    chk(32'(stall)); chk(x_a_out);

    step();
    w_wr_en = 1; w_wr_reg = 7; w_wr_data = 32'h1234;
    x_a_use = 1; x_a_reg = 7; x_a_rf = 0;
    #1;
    push_exp("lu_w_data", 32'h1234); push_exp("lu_released", 0);
    chk(x_a_out); chk(32'(stall));

    // Register zero is never forwarded and never stalls.
    step();
    m_wr_en = 1; m_wr_reg = 0; m_wr_data = 7; m_is_load = 1;
    x_a_use = 1; x_a_reg = 0; x_a_rf = 0;
    #1;
    push_exp("r0_a", 0); push_exp("r0_stall", 0);
    chk(x_a_out); chk(32'(stall));

    // Multdiv scoreboard: issue r9, dependent X stalls until md_done.
    step();
    md_start = 1; md_dst = 9; x_is_md = 1;
    #1;
    push_exp("md_issue_busy", 0); push_exp("md_issue_stall", 0);
    chk(32'(md_busy)); chk(32'(stall));

    for (int i = 0; i < 3; i++) begin
      step();
      x_a_use = 1; x_a_reg = 9; x_a_rf = 0;
      #1;
      push_exp("md_busy", 1); push_exp("md_dep_stall", 1);
      chk(32'(md_busy)); chk(32'(stall));
    end

    step();
    x_a_use = 1; x_a_reg = 9; x_a_rf = 0;
    md_done = 1; md_result = 42;
    #1;
    push_exp("md_fwd", 42); push_exp("md_done_stall", 0);
    chk(x_a_out); chk(32'(stall));

    step();
    x_a_use = 1; x_a_reg = 9; x_a_rf = 32'h3;
    #1;
    push_exp("md_idle_busy", 0); push_exp("md_idle_stall", 0);
    push_exp("md_idle_a", 32'h3); push_exp("md_no_tmo", 0);
    chk(32'(md_busy)); chk(32'(stall)); chk(x_a_out); chk(32'(md_timeout));

    // Timeout: BUSY with no md_done; second multdiv in X also stalls.
    step();
    md_start = 1; md_dst = 10;
    step();
    x_is_md = 1;
    #1;
    push_exp("xmd_stall", 1); chk(32'(stall));
    for (int k = 2; k <= 64; k++) begin
      step();
      x_is_md = 1;
    end
    #1;
    push_exp("tmo_before", 0); chk(32'(md_timeout));
    step();
    x_is_md = 1;
    #1;
    push_exp("tmo_set", 1); push_exp("tmo_busy", 1);
    chk(32'(md_timeout)); chk(32'(md_busy));

    // Reset mid-BUSY: everything clears immediately.
    step();
    x_is_md = 1; x_a_use = 1; x_a_reg = 10;
    reset_n = 1'b0;
    #1;
    push_exp("rst_mid_busy", 0); push_exp("rst_mid_stall", 0); push_exp("rst_mid_tmo", 0);
    chk(32'(md_busy)); chk(32'(stall)); chk(32'(md_timeout));
    @(negedge clock);
    reset_n = 1'b1;

    // Stray md_done after reset is ignored; history was flushed.
    step();
    md_done = 1; md_result = 32'hDEAD;
    x_a_use = 1; x_a_reg = 10; x_a_rf = 32'h3;
    x_b_use = 1; x_b_reg = 4; x_b_rf = 32'h66;
    #1;
    push_exp("stray_done_a", 32'h3); push_exp("hist_flushed", 32'h66);
    chk(x_a_out); chk(x_b_out);
    step();
    #1;
    push_exp("stray_busy", 0); chk(32'(md_busy));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
